beam_peak_search: RTL
=====================

Name: beam_peak_search

Overview:
- Downstream consumer of the 4-channel beamformer combiner.
- Sweeps steering-angle indices and drives angle_idx to the steering-vector ROM that feeds the combiner.
- Accumulates 2^SNAP_LOG2 integer power samples (|I_tot|^2+|Q_tot|^2) per angle and returns the angle with maximum accumulated power.
- One sweep per start pulse; feeds the DOA result register.

Parameters:
PWR_WIDTH, 54, unsigned power sample width (2 x 27-bit combiner output)
NUM_ANGLES, 181, angles per sweep (index 0..NUM_ANGLES-1)
ANGLE_W, 8, angle index width; must satisfy 2^ANGLE_W >= NUM_ANGLES
SNAP_LOG2, 4, log2 of snapshots accumulated per angle
SETTLE, 2, cycles after angle change before samples are accepted (ROM + combiner latency); minimum 1
ACC_W, PWR_WIDTH+SNAP_LOG2, accumulator and best_pwr width (derived)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
start  in  1  begin sweep; honoured only in IDLE
busy  out  1  high from the cycle after an accepted start through the last COMPARE
angle_idx  out  ANGLE_W  current steering index to ROM
pwr_in  in  PWR_WIDTH  unsigned power sample for angle_idx
pwr_valid  in  1  pwr_in valid
pwr_ready  out  1  high only in ACCUM
best_idx  out  ANGLE_W  index of maximum accumulated power
best_pwr  out  ACC_W  maximum accumulated power
done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset: state IDLE. busy=0, angle_idx=0, pwr_ready=0, best_idx=0, best_pwr=0, done=0. Accumulator, snapshot counter and settle counter are cleared.
- Reset asserted mid-sweep aborts the sweep and forces the same values on the next edge. No done pulse is issued.
- IDLE:
  - start=1 -> SETTLE; angle_idx=0; accumulator cleared.
  - pwr_valid is ignored (pwr_ready=0).
- SETTLE:
  - Lasts exactly SETTLE cycles, then -> ACCUM.
  - pwr_ready=0; any samples presented are discarded.
- ACCUM:
  - pwr_ready=1. Each cycle with pwr_valid=1 adds zero-extended pwr_in to the accumulator and increments the snapshot counter.
  - Cycles with pwr_valid=0 stall without penalty.
  - After 2^SNAP_LOG2 accepted samples -> COMPARE. pwr_ready drops in the cycle after the last accepted sample.
- COMPARE (1 cycle):
  - If angle_idx==0 or acc > best_pwr (strict), update best_pwr<=acc and best_idx<=angle_idx.
  - Ties keep the lower index.
  - If angle_idx==NUM_ANGLES-1 -> DONE. Otherwise angle_idx+1, clear accumulator, -> SETTLE.
- DONE (1 cycle): done=1, busy=0, then -> IDLE.
- best_idx/best_pwr hold the previous sweep result until the first COMPARE of the next sweep overwrites them.
- Widths: ACC_W accommodates 2^SNAP_LOG2 full-scale samples, so no overflow or saturation logic is needed.
- start while busy, or in the DONE cycle, is ignored.
- start in the same cycle as rst: rst wins.
- Latency with no stalls: start at cycle T -> done=1 at T+1+NUM_ANGLES*(SETTLE+2^SNAP_LOG2+1).
- angle_idx stays at NUM_ANGLES-1 after a sweep until the next start or reset.

Test Plan:
Bench parameters: NUM_ANGLES=4, SNAP_LOG2=2, SETTLE=2, PWR_WIDTH=54.
1. Apply reset 3 cycles with pwr_valid=1 -> all outputs 0; pwr_ready stays 0 in IDLE.
2. start; pwr_valid held 1; power 10/50/30/20 for angles 0..3 -> best_idx=1, best_pwr=200, done single pulse at T+29, busy high T+1..T+28.
3. Tie case: powers 5/25/7/25 -> best_idx=1, best_pwr=100.
4. Drive 1000 on pwr_in with valid during SETTLE, and toggle pwr_valid every other cycle in ACCUM with power 3 at angle 2 only -> settle-period values not counted; angle 2 accumulates 12; done delayed by exactly the number of stall cycles.
5. All samples 2^54-1 at every angle -> best_pwr=4*(2^54-1) with no wrap; best_idx=0.
6. Assert rst during angle 2 ACCUM -> next cycle IDLE with outputs 0 and no done. A start pulsed while busy in a new sweep is ignored. The next sweep starts at angle_idx=0 and gives the correct result.

Source files
------------

// File: rtl/beam_peak_search.sv
// Steering-angle sweep that accumulates combiner power per angle
// and reports the angle with the largest accumulated power.
module beam_peak_search #(
  parameter int PWR_WIDTH  = 54,
  parameter int NUM_ANGLES = 181,
  parameter int ANGLE_W    = 8,
  parameter int SNAP_LOG2  = 4,
  parameter int SETTLE     = 2,
  parameter int ACC_W      = PWR_WIDTH + SNAP_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic [ANGLE_W-1:0]   angle_idx,
  input  logic [PWR_WIDTH-1:0] pwr_in,
  input  logic                 pwr_valid,
  output logic                 pwr_ready,
  output logic [ANGLE_W-1:0]   best_idx,
  output logic [ACC_W-1:0]     best_pwr,
  output logic                 done
);

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SN_W = SNAP_LOG2 + 1;

  localparam logic [SC_W-1:0]    SETTLE_LAST = SC_W'(SETTLE - 1);
  localparam logic [SN_W-1:0]    SNAP_LAST   = SN_W'((1 << SNAP_LOG2) - 1);
  localparam logic [ANGLE_W-1:0] ANGLE_LAST  = ANGLE_W'(NUM_ANGLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ACCUM,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [SC_W-1:0]    r_settle;
  logic [SN_W-1:0]    r_snap;
  logic [ACC_W-1:0]   r_acc;
  logic [ANGLE_W-1:0] r_angle;
  logic [ANGLE_W-1:0] r_best_idx;
  logic [ACC_W-1:0]   r_best_pwr;
  logic               r_busy;
  logic               r_ready;
  logic               r_done;

  logic [ACC_W-1:0]   w_pwr_ext;
  logic               w_take_best;

  assign w_pwr_ext   = ACC_W'(pwr_in);
  // First angle always seeds the result; later angles need strictly more
  assign w_take_best = (r_angle == '0) || (r_acc > r_best_pwr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_settle   <= '0;
      r_snap     <= '0;
      r_acc      <= '0;
      r_angle    <= '0;
      r_best_idx <= '0;
      r_best_pwr <= '0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_SETTLE;
            r_busy   <= 1'b1;
            r_angle  <= '0;
            r_acc    <= '0;
            r_settle <= '0;
            r_snap   <= '0;
          end
        end
        S_SETTLE: begin
          if (r_settle == SETTLE_LAST) begin
            r_state  <= S_ACCUM;
            r_ready  <= 1'b1;
            r_settle <= '0;
          end else begin
            r_settle <= r_settle + SC_W'(1);
          end
        end
        S_ACCUM: begin
          if (pwr_valid) begin
            r_acc <= r_acc + w_pwr_ext;
            if (r_snap == SNAP_LAST) begin
              r_state <= S_COMPARE;
              r_ready <= 1'b0;
              r_snap  <= '0;
            end else begin
              r_snap <= r_snap + SN_W'(1);
            end
          end
        end
        S_COMPARE: begin
          if (w_take_best) begin
            r_best_pwr <= r_acc;
            r_best_idx <= r_angle;
          end
          if (r_angle == ANGLE_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_SETTLE;
            r_angle <= r_angle + ANGLE_W'(1);
            r_acc   <= '0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign angle_idx = r_angle;
  assign pwr_ready = r_ready;
  assign best_idx  = r_best_idx;
  assign best_pwr  = r_best_pwr;
  assign done      = r_done;

endmodule
